// File: rtl/wiphase_spi_slave.sv
// wiphase_spi_slave: SPI mode-0 (CPOL=0, CPHA=0, MSB first) responder with a CPU
// register port (rxdata, txdata, status, control, eop value). All SPI pins are
// oversampled on clk. Optional feature macro: SPI_SLAVE_MISO_OE_EN adds MISO_oe
// and holds MISO while deselected so the line can be tri-stated at top level.
`timescale 1ns/1ps
module wiphase_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_from_cpu,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic        MISO_oe,
`endif
    output logic        MISO
);

    localparam int          CW        = $clog2(DATABITS + 1);
    localparam logic [2:0]  ADDR_RX   = 3'd0;
    localparam logic [2:0]  ADDR_TX   = 3'd1;
    localparam logic [2:0]  ADDR_STAT = 3'd2;
    localparam logic [2:0]  ADDR_CTRL = 3'd3;
    localparam logic [2:0]  ADDR_EOP  = 3'd6;
    localparam logic [15:0] CTRL_MASK = 16'h03D8;  // enables 9..3, bit 5 (TMT) not enabled

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t                r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
    logic                  r_sclk_prev, r_ss_prev;
    logic [DATABITS-1:0]   r_tx_shift, r_rx_shift, r_tx_holding, r_rx_holding, r_eop_val;
    logic [CW-1:0]         r_bitcnt;
    logic                  r_tx_primed, r_rrdy, r_roe, r_toe, r_eop;
    logic [15:0]           r_ctrl, r_data_to_cpu;
    logic                  r_irq, r_rd_req_d, r_wr_req_d;

    logic w_sclk_s, w_mosi_s, w_ss_s, w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic w_shifting, w_rise_act, w_fall_act, w_byte_done, w_reload;
    logic w_rd_stb, w_wr_stb, w_rx_read, w_tx_write, w_stat_write, w_trdy, w_tmt, w_eop_set;
    logic [DATABITS-1:0] w_rx_next, w_tx_data;
    logic [15:0]         w_status, w_rd_data;
    logic                w_unused;

    // Synchronized pins and edge detection on the synchronized copies
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_ss_rise   = w_ss_s & ~r_ss_prev;
    assign w_ss_fall   = ~w_ss_s & r_ss_prev;

    // Shift engine qualifiers; deselect takes priority over any SCLK edge
    assign w_shifting  = (r_state == ST_SHIFT) & ~w_ss_rise;
    assign w_rise_act  = w_shifting & w_sclk_rise & (r_bitcnt != CW'(DATABITS));
    assign w_fall_act  = w_shifting & w_sclk_fall;
    assign w_byte_done = w_rise_act & (r_bitcnt == CW'(DATABITS - 1));
    assign w_reload    = (r_state == ST_LOAD) | (w_fall_act & (r_bitcnt == CW'(DATABITS)));
    assign w_rx_next   = DATABITS'({r_rx_shift, w_mosi_s});

    // CPU port: a strobe only on the first cycle of each access
    assign w_rd_stb     = spi_select & ~read_n & ~r_rd_req_d;
    assign w_wr_stb     = spi_select & ~write_n & ~r_wr_req_d;
    assign w_rx_read    = w_rd_stb & (mem_addr == ADDR_RX);
    assign w_tx_write   = w_wr_stb & (mem_addr == ADDR_TX);
    assign w_stat_write = w_wr_stb & (mem_addr == ADDR_STAT);
    assign w_tx_data    = data_from_cpu[DATABITS-1:0];
    assign w_trdy       = ~r_tx_primed;
    assign w_tmt        = ~r_tx_primed & (r_state == ST_IDLE);
    assign w_eop_set    = (w_byte_done & (w_rx_next == r_eop_val)) |
                          (w_tx_write & w_trdy & (w_tx_data == r_eop_val));
    assign w_status     = {6'b0, r_eop, r_roe | r_toe, r_rrdy, w_trdy, w_tmt, r_toe, r_roe, 3'b0};
    assign w_unused     = ^data_from_cpu;

    // Pin synchronizers and edge-detect history
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_prev <= w_sclk_s;
            r_ss_prev   <= w_ss_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Frame next-state: only a fresh SS_n falling edge starts a frame
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss_fall) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = w_ss_rise ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: if (w_ss_rise) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Shift registers, bit counter and tx holding/primed handshake
    // NOTE: holding registers are ordinary flops, so they reset like everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_bitcnt     <= '0;
            r_tx_holding <= '0;
            r_tx_primed  <= 1'b0;
        end else begin
            if (w_reload) begin
                r_tx_shift <= r_tx_primed ? r_tx_holding : '0;
                r_bitcnt   <= '0;
            end else if (w_fall_act) begin
                r_tx_shift <= r_tx_shift << 1;
            end
            if (w_rise_act) begin
                r_rx_shift <= w_rx_next;
                r_bitcnt   <= r_bitcnt + 1'b1;
            end
            if ((r_state != ST_IDLE) && w_ss_rise) r_bitcnt <= '0;
            // write is only accepted while unprimed, so it never collides with a real consume
            if (w_tx_write && w_trdy) begin
                r_tx_holding <= w_tx_data;
                r_tx_primed  <= 1'b1;
            end else if (w_reload) begin
                r_tx_primed  <= 1'b0;
            end
        end
    end

    // Receive holding register and status flags; a completing byte beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_holding <= '0;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_eop        <= 1'b0;
        end else begin
            if (w_byte_done) r_rx_holding <= w_rx_next;
            if (w_byte_done)                     r_rrdy <= 1'b1;
            else if (w_rx_read || w_stat_write)  r_rrdy <= 1'b0;
            if (w_stat_write)                              r_roe <= 1'b0;
            else if (w_byte_done && r_rrdy && !w_rx_read)  r_roe <= 1'b1;
            if (w_stat_write)                  r_toe <= 1'b0;
            else if (w_tx_write && !w_trdy)    r_toe <= 1'b1;
            if (w_eop_set)          r_eop <= 1'b1;
            else if (w_stat_write)  r_eop <= 1'b0;
        end
    end

    // Control and end-of-packet value registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_eop_val <= '0;
        end else begin
            if (w_wr_stb && (mem_addr == ADDR_CTRL)) r_ctrl    <= data_from_cpu & CTRL_MASK;
            if (w_wr_stb && (mem_addr == ADDR_EOP))  r_eop_val <= w_tx_data;
        end
    end

    // Read mux; unmapped (and write-only) addresses return rxdata
    always_comb begin
        w_rd_data = 16'(r_rx_holding);
        case (mem_addr)
            ADDR_STAT: w_rd_data = w_status;
            ADDR_CTRL: w_rd_data = r_ctrl;
            ADDR_EOP:  w_rd_data = 16'(r_eop_val);
            default:   w_rd_data = 16'(r_rx_holding);
        endcase
    end

    // Registered read data, interrupt and access-edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_to_cpu <= '0;
            r_irq         <= 1'b0;
            r_rd_req_d    <= 1'b0;
            r_wr_req_d    <= 1'b0;
        end else begin
            r_data_to_cpu <= w_rd_data;
            r_irq         <= |(w_status & r_ctrl);
            r_rd_req_d    <= spi_select & ~read_n;
            r_wr_req_d    <= spi_select & ~write_n;
        end
    end

    assign data_to_cpu   = r_data_to_cpu;
    assign irq           = r_irq;
    assign dataavailable = r_rrdy;
    assign readyfordata  = w_trdy;
    assign endofpacket   = r_eop;

`ifdef SPI_SLAVE_MISO_OE_EN
    logic r_miso_oe;

    // Output enable follows the synchronized select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_miso_oe <= 1'b0;
        else          r_miso_oe <= ~w_ss_s;
    end

    assign MISO_oe = r_miso_oe;
    assign MISO    = r_tx_shift[DATABITS-1];
`else
    assign MISO    = (r_state != ST_IDLE) & ~w_ss_s & r_tx_shift[DATABITS-1];
`endif

endmodule

// File: tb/tb_wiphase_spi_slave.sv
// Directed testbench for wiphase_spi_slave (default build, DATABITS=8, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_wiphase_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_from_cpu = '0;
    logic [2:0]  mem_addr = '0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic        spi_select = 1'b0;
    logic [15:0] data_to_cpu;
    logic        irq, dataavailable, readyfordata, endofpacket;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SS_n = 1'b1;
    logic        MISO;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wiphase_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .data_from_cpu(data_from_cpu), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .spi_select(spi_select), .data_to_cpu(data_to_cpu),
        .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata),
        .endofpacket(endofpacket), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
    );

    // All stimulus is applied 1 ns after a rising clk edge
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
        wait_clk(2);
        spi_select = 1'b0; write_n = 1'b1;
        wait_clk(1);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
        wait_clk(1);
        d = data_to_cpu;
        wait_clk(1);
        spi_select = 1'b0; read_n = 1'b1;
        wait_clk(1);
    endtask

    // One mode-0 bit at clk/10: MISO sampled just before SCLK rises
    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        wait_clk(5);
        m = MISO;
        SCLK = 1'b1;
        wait_clk(5);
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] m);
        logic b;
        m = '0;
        SS_n = 1'b0;
        wait_clk(10);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(w[i], b);
            m = {m[14:0], b};
        end
        wait_clk(6);
        SS_n = 1'b1; MOSI = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        n_tests++; if (data_to_cpu !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h exp 0000", data_to_cpu); end
        n_tests++; if ({irq, MISO, dataavailable, endofpacket} !== 4'b0000) begin n_fail++; $display("FAIL rst_outs got %b exp 0000", {irq, MISO, dataavailable, endofpacket}); end
        reset_n = 1'b1;
        wait_clk(5);
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h0060) begin n_fail++; $display("FAIL rst_status got %h exp 0060", rd); end
        bus_read(3'd3, rd);
        n_tests++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrl got %h exp 0000", rd); end
    endtask

    task automatic test_basic();
        logic [15:0] rd, m;
        bus_write(3'd1, 16'h00A5);
        n_tests++; if (readyfordata !== 1'b0) begin n_fail++; $display("FAIL t1_trdy_primed got %b exp 0", readyfordata); end
        spi_frame(16'h003C, 8, m);
        n_tests++; if (m[7:0] !== 8'hA5) begin n_fail++; $display("FAIL t1_miso got %h exp a5", m[7:0]); end
        n_tests++; if (dataavailable !== 1'b1) begin n_fail++; $display("FAIL t1_rrdy got %b exp 1", dataavailable); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h00E0) begin n_fail++; $display("FAIL t1_status got %h exp 00e0", rd); end
        bus_read(3'd0, rd);
        n_tests++; if (rd !== 16'h003C) begin n_fail++; $display("FAIL t1_rxdata got %h exp 003c", rd); end
        n_tests++; if ({dataavailable, readyfordata} !== 2'b01) begin n_fail++; $display("FAIL t1_after_read got %b exp 01", {dataavailable, readyfordata}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd, m;
        bus_write(3'd3, 16'h0100);
        bus_read(3'd3, rd);
        n_tests++; if (rd !== 16'h0100) begin n_fail++; $display("FAIL t2_ctrl got %h exp 0100", rd); end
        bus_write(3'd1, 16'h005A);
        spi_frame(16'h1122, 16, m);
        n_tests++; if (m !== 16'h5A00) begin n_fail++; $display("FAIL t2_miso got %h exp 5a00", m); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t2_irq got %b exp 1", irq); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h01E8) begin n_fail++; $display("FAIL t2_status got %h exp 01e8", rd); end
        bus_read(3'd0, rd);
        n_tests++; if (rd !== 16'h0022) begin n_fail++; $display("FAIL t2_rxdata got %h exp 0022", rd); end
        bus_write(3'd2, 16'h0000);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t2_irq_clr got %b exp 0", irq); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h0060) begin n_fail++; $display("FAIL t2_status_clr got %h exp 0060", rd); end
        bus_write(3'd3, 16'h0000);
    endtask

    task automatic test_abort();
        logic [15:0] rd, m;
        bus_write(3'd1, 16'h0033);
        spi_frame(16'h001F, 5, m);
        n_tests++; if (m[4:0] !== 5'b00110) begin n_fail++; $display("FAIL t3_miso_part got %b exp 00110", m[4:0]); end
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL t3_rrdy got %b exp 0", dataavailable); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h0060) begin n_fail++; $display("FAIL t3_status got %h exp 0060", rd); end
        spi_frame(16'h007E, 8, m);
        n_tests++; if (m[7:0] !== 8'h00) begin n_fail++; $display("FAIL t3_miso_underrun got %h exp 00", m[7:0]); end
        bus_read(3'd0, rd);
        n_tests++; if (rd !== 16'h007E) begin n_fail++; $display("FAIL t3_rxdata got %h exp 007e", rd); end
    endtask

    task automatic test_tx_overrun();
        logic [15:0] rd, m;
        bus_write(3'd1, 16'h00C3);
        bus_write(3'd1, 16'h0099);
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h0110) begin n_fail++; $display("FAIL t4_status_toe got %h exp 0110", rd); end
        spi_frame(16'h0042, 8, m);
        n_tests++; if (m[7:0] !== 8'hC3) begin n_fail++; $display("FAIL t4_miso got %h exp c3", m[7:0]); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h01F0) begin n_fail++; $display("FAIL t4_status got %h exp 01f0", rd); end
        bus_read(3'd0, rd);
        n_tests++; if (rd !== 16'h0042) begin n_fail++; $display("FAIL t4_rxdata got %h exp 0042", rd); end
        bus_write(3'd2, 16'h0000);
    endtask

    task automatic test_eop();
        logic [15:0] rd, m;
        bus_write(3'd6, 16'h000D);
        bus_read(3'd6, rd);
        n_tests++; if (rd !== 16'h000D) begin n_fail++; $display("FAIL t5_eopval got %h exp 000d", rd); end
        spi_frame(16'h000D, 8, m);
        n_tests++; if (endofpacket !== 1'b1) begin n_fail++; $display("FAIL t5_eop got %b exp 1", endofpacket); end
        spi_frame(16'h000D, 8, m);
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h03E8) begin n_fail++; $display("FAIL t5_status got %h exp 03e8", rd); end
        bus_write(3'd2, 16'h0000);
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h0060) begin n_fail++; $display("FAIL t5_status_clr got %h exp 0060", rd); end
        n_tests++; if ({endofpacket, dataavailable} !== 2'b00) begin n_fail++; $display("FAIL t5_outs_clr got %b exp 00", {endofpacket, dataavailable}); end
    endtask

    task automatic test_read_collision();
        logic [15:0] rd, m;
        logic        b;
        spi_frame(16'h0055, 8, m);
        SS_n = 1'b0;
        wait_clk(10);
        for (int i = 7; i >= 1; i--) spi_bit(1'(8'h66 >> i), b);
        MOSI = 1'b0;
        wait_clk(5);
        SCLK = 1'b1;
        wait_clk(2);
        // rxdata read strobe lands in the cycle the last rising edge completes the byte
        mem_addr = 3'd0; spi_select = 1'b1; read_n = 1'b0;
        wait_clk(1);
        spi_select = 1'b0; read_n = 1'b1;
        wait_clk(2);
        SCLK = 1'b0;
        wait_clk(6);
        SS_n = 1'b1;
        wait_clk(10);
        n_tests++; if (dataavailable !== 1'b1) begin n_fail++; $display("FAIL t6_rrdy got %b exp 1", dataavailable); end
        bus_read(3'd2, rd);
        n_tests++; if (rd !== 16'h00E0) begin n_fail++; $display("FAIL t6_status got %h exp 00e0", rd); end
        bus_read(3'd0, rd);
        n_tests++; if (rd !== 16'h0066) begin n_fail++; $display("FAIL t6_rxdata got %h exp 0066", rd); end
    endtask

    initial begin
        wait_clk(3);
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_tx_overrun();
        test_eop();
        test_read_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wiphase_spi_slave.md
Name: wiphase_spi_slave

Overview:
SPI slave (responder) peripheral: the far end of the system SPI master protocol. Mode 0 only: CPOL=0, CPHA=0, MSB first.
Sits on the CPU bus with a register map matching the master's: rx data, tx data, status, control and end-of-packet value.
Receives MOSI bytes into a holding register and returns the CPU-loaded tx byte on MISO during the same frame.
All SPI pins are oversampled on clk; no SCLK-domain logic.

Parameters:
DATABITS, 8, frame width in bits (supported range 1..16).
SYNC_STAGES, 2, synchronizer depth for SCLK, MOSI and SS_n (minimum 2).

Ports:
clk  input  1  system clock; SCLK must not exceed clk/8.
reset_n  input  1  asynchronous, active-low reset.
data_from_cpu  input  16  CPU write data.
mem_addr  input  3  register address: 0 rxdata (r), 1 txdata (w), 2 status (r / write-to-clear), 3 control (r/w), 6 eop value (r/w).
read_n  input  1  active-low read.
write_n  input  1  active-low write.
spi_select  input  1  chip select for this register port.
data_to_cpu  output  16  registered read data.
irq  output  1  registered interrupt.
dataavailable  output  1  equals RRDY.
readyfordata  output  1  equals TRDY.
endofpacket  output  1  equals EOP.
SCLK  input  1  SPI clock from the master.
MOSI  input  1  SPI data from the master.
SS_n  input  1  active-low slave select.
MISO  output  1  SPI data to the master.

Behaviour:
- Reset values: data_to_cpu=0, irq=0, MISO=0, all status bits 0, control=0, eop value=0, shift registers=0, bit counter=0.
- Bus access:
  - Two-cycle access, as on the master: a strobe is generated only on the first cycle of spi_select & ~read_n / ~write_n.
  - data_to_cpu is registered from the addressed register every cycle.
  - Unmapped addresses read rxdata.
- Status register (bits): 9 EOP, 8 E (=ROE|TOE), 7 RRDY, 6 TRDY, 5 TMT, 4 TOE, 3 ROE. All other bits read 0.
  - TRDY = ~tx_primed.
  - TMT = ~tx_primed & ~in_frame.
- Control register: bits 9..3 are interrupt enables in the same positions as the status bits; bit 5 reads 0.
- irq is registered: OR over (status bit & enable), with E's enable covering ROE|TOE.
- Synchronizer and edge detect:
  - SCLK, MOSI and SS_n each pass through SYNC_STAGES flops.
  - Rising and falling edges of SCLK and SS_n are detected on the synchronized values.
  - Pin-to-action latency is SYNC_STAGES+1 clk.
- States:
  - IDLE: SS_n high; MISO=0.
  - LOAD: one cycle after SS_n falls.
    - If tx_primed: tx_shift <= tx_holding and tx_primed cleared.
    - Otherwise tx_shift <= 0 (underrun, no flag).
    - bitcnt <= 0; then go to SHIFT.
  - SHIFT:
    - On an SCLK rising edge: rx_shift <= {rx_shift, MOSI_sync} and bitcnt increments.
    - On an SCLK falling edge: tx_shift shifts left.
    - MISO = tx_shift[DATABITS-1] whenever SS_n is low.
- Byte completion:
  - Triggered on the rising edge that makes bitcnt reach DATABITS.
  - rx_holding <= new byte and RRDY <= 1.
  - ROE <= 1 if RRDY was already 1. rx_holding is overwritten regardless.
  - EOP <= 1 if the byte equals the eop value.
  - The following SCLK falling edge reloads tx_shift as in LOAD, supporting back-to-back bytes in one frame, and resets bitcnt.
- SS_n rises mid-byte: go to IDLE immediately; the partial byte is discarded; no RRDY, no ROE; a loaded tx byte is consumed.
- txdata write:
  - If TRDY: tx_holding <= data[DATABITS-1:0] and tx_primed <= 1. EOP <= 1 if the written value equals the eop value.
  - If not TRDY: data dropped and TOE <= 1.
- rxdata read clears RRDY. If a byte completes in the same cycle, the set wins (RRDY=1) and ROE is not set.
- status write clears EOP, RRDY, ROE and TOE. A same-cycle byte completion wins for RRDY and EOP.
- Reset asserted mid-frame: everything returns to reset values. After release, the block waits for a fresh SS_n falling edge; SCLK activity while SS_n is already low is ignored until then.

Optional Feature:
SPI_SLAVE_MISO_OE_EN:
- Defined: adds output MISO_oe (1 bit) = ~SS_n_sync, reset 0. MISO then holds its last bit while deselected so the shared line can be tri-stated at top level.
- Undefined: no MISO_oe port; MISO is forced to 0 while deselected.

Test Plan:
1. Write txdata=0xA5, then the master sends 0x3C under SS_n low at clk/10 → MISO carries bits 1,0,1,0,0,1,0,1; RRDY=1 and rxdata reads 0x3C; TRDY=1.
2. Two back-to-back bytes 0x11 then 0x22 with no read in between → rxdata=0x22, ROE=1, E=1; irq asserts if control=0x0100.
3. SS_n raised after 5 SCLK rising edges → RRDY stays 0, bitcnt reset; the next full frame 0x7E is received correctly.
4. Write txdata twice with no frame in between → the second write is dropped, TOE=1, and the first value is transmitted.
5. eop value=0x0D, master sends 0x0D → EOP=1, endofpacket=1; a status write clears EOP, RRDY, ROE and TOE to 0.
6. Read rxdata in the same cycle as a byte completes → RRDY=1, ROE=0.
